// File: rtl/maxterm_extractor.sv
// Sweeps every input combination into a function under test, collects the
// indices where it returned 0 (maxterms) and compares them to an expected mask.
module maxterm_extractor #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [(2**N_VARS)-1:0]   expect_i,
  input  logic                     f_in_i,
  output logic [N_VARS-1:0]        vars_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [(2**N_VARS)-1:0]   maxterms_o,
  output logic [N_VARS:0]          count_o,
  output logic                     match_o
);

  localparam int W = 2**N_VARS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [3:0]        SETTLE_C = SETTLE[3:0];
  localparam logic [N_VARS-1:0] IDX_MAX  = {N_VARS{1'b1}};
  localparam logic [N_VARS-1:0] IDX_ONE  = {{(N_VARS-1){1'b0}}, 1'b1};
  localparam logic [N_VARS:0]   CNT_ONE  = {{N_VARS{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [N_VARS-1:0] idx_q, idx_d;
  logic [3:0]        sc_q, sc_d;
  logic [W-1:0]      exp_q, exp_d;
  logic [W-1:0]      mt_q, mt_d;
  logic [W-1:0]      mt_new_s;
  logic [N_VARS:0]   cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sc_d     = sc_q;
    exp_d    = exp_q;
    mt_d     = mt_q;
    mt_new_s = mt_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start_i) begin
          state_d = ST_SCAN;
          idx_d   = {N_VARS{1'b0}};
          sc_d    = 4'd0;
          exp_d   = expect_i;
          mt_d    = {W{1'b0}};
          cnt_d   = {(N_VARS+1){1'b0}};
          match_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // VARS is held SETTLE+1 cycles; F_IN is only looked at on the last one.
        if (sc_q != SETTLE_C) begin
          sc_d = sc_q + 4'd1;
        end else begin
          if (!f_in_i) begin
            mt_new_s[idx_q] = 1'b1;
            cnt_d           = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          mt_d = mt_new_s;
          if (idx_q != IDX_MAX) begin
            idx_d = idx_q + IDX_ONE;
            sc_d  = 4'd0;
          end else begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (mt_new_s == exp_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= {N_VARS{1'b0}};
      sc_q    <= 4'd0;
      exp_q   <= {W{1'b0}};
      mt_q    <= {W{1'b0}};
      cnt_q   <= {(N_VARS+1){1'b0}};
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sc_q    <= sc_d;
      exp_q   <= exp_d;
      mt_q    <= mt_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vars_o     = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign maxterms_o = mt_q;
  assign count_o    = cnt_q;
  assign match_o    = match_q;

endmodule

// File: tb/tb_maxterm_extractor.sv
// Directed bench for maxterm_extractor: three instances cover SETTLE=1 (main),
// SETTLE=3 and SETTLE=0 (both fed by a registered copy of the function).
module tb_maxterm_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start6 = 1'b0;
  logic [15:0] expect_v = 16'h5507;
  logic [15:0] mt_set = 16'h5507;
  int          fmode = 0;

  logic        f_main;
  logic [3:0]  vars;
  logic        busy, done, match;
  logic [15:0] mt;
  logic [4:0]  cnt;

  logic        f_reg3, f_reg0;
  logic [3:0]  vars3, vars0;
  logic        busy3, done3, match3, busy0, done0, match0;
  logic [15:0] mt3, mt0;
  logic [4:0]  cnt3, cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Function under test: 0 exactly on the maxterm set, or tied 1 / tied 0.
  assign f_main = (fmode == 0) ? ~mt_set[vars] : ((fmode == 1) ? 1'b1 : 1'b0);

  always_ff @(posedge clk) begin
    f_reg3 <= ~mt_set[vars3];
    f_reg0 <= ~mt_set[vars0];
  end

  maxterm_extractor #(.N_VARS(4), .SETTLE(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .expect_i(expect_v), .f_in_i(f_main),
    .vars_o(vars), .busy_o(busy), .done_o(done), .maxterms_o(mt), .count_o(cnt), .match_o(match)
  );

  maxterm_extractor #(.N_VARS(4), .SETTLE(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start6), .expect_i(expect_v), .f_in_i(f_reg3),
    .vars_o(vars3), .busy_o(busy3), .done_o(done3), .maxterms_o(mt3), .count_o(cnt3), .match_o(match3)
  );

  maxterm_extractor #(.N_VARS(4), .SETTLE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start6), .expect_i(expect_v), .f_in_i(f_reg0),
    .vars_o(vars0), .busy_o(busy0), .done_o(done0), .maxterms_o(mt0), .count_o(cnt0), .match_o(match0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int lat0;
    int lat3;
    logic gap;
    logic seen;
    logic [3:0] vars20;

    // 1. reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_vars", 32'(vars), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_mt", 32'(mt), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    check("rst_match", 32'(match), 32'h0);

    // 2. maxterm function {0,1,2,8,10,12,14}
    fmode = 0;
    pulse_start();
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_vars0", 32'(vars), 32'h0);
    wait_done(40, n);
    check("t2_latency", 32'(n), 32'd32);
    check("t2_mt", 32'(mt), 32'h5507);
    check("t2_cnt", 32'(cnt), 32'd7);
    check("t2_match", 32'(match), 32'h1);
    check("t2_busy_fin", 32'(busy), 32'h0);
    tick();
    check("t2_done_1cyc", 32'(done), 32'h0);
    check("t2_mt_hold", 32'(mt), 32'h5507);
    check("t2_vars_hold", 32'(vars), 32'hF);

    // 3. F tied 1, then tied 0
    fmode = 1;
    pulse_start();
    check("t3_clear", 32'(mt), 32'h0);
    wait_done(40, n);
    check("t3a_latency", 32'(n), 32'd32);
    check("t3a_mt", 32'(mt), 32'h0);
    check("t3a_cnt", 32'(cnt), 32'd0);
    fmode = 2;
    pulse_start();
    wait_done(40, n);
    check("t3b_mt", 32'(mt), 32'hFFFF);
    check("t3b_cnt", 32'(cnt), 32'd16);
    check("t3b_match", 32'(match), 32'h0);

    // 4. START held high through a scan
    fmode = 0;
    start = 1'b1;
    tick();
    gap = 1'b0;
    vars20 = 4'h0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k < 32 && !busy) gap = 1'b1;
      if (k == 20) vars20 = vars;
      if (done) begin
        n = k;
        break;
      end
    end
    check("t4_busy_cont", 32'(gap), 32'h0);
    check("t4_no_restart", 32'(vars20), 32'd10);
    check("t4_latency", 32'(n), 32'd32);
    tick();
    check("t4_restart_busy", 32'(busy), 32'h1);
    check("t4_restart_vars", 32'(vars), 32'h0);
    check("t4_restart_mt", 32'(mt), 32'h0);
    start = 1'b0;
    wait_done(40, n);
    check("t4_second_latency", 32'(n), 32'd32);
    check("t4_second_mt", 32'(mt), 32'h5507);

    // 5. reset mid-scan, then a clean scan
    pulse_start();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_vars", 32'(vars), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    check("t5_mt", 32'(mt), 32'h0);
    check("t5_cnt", 32'(cnt), 32'h0);
    check("t5_match", 32'(match), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("t5_no_done", 32'(seen), 32'h0);
    pulse_start();
    wait_done(40, n);
    check("t5_latency", 32'(n), 32'd32);
    check("t5_mt", 32'(mt), 32'h5507);
    check("t5_cnt", 32'(cnt), 32'd7);
    check("t5_match", 32'(match), 32'h1);

    // 6. registered function: SETTLE=3 correct, SETTLE=0 off by one index
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    lat0 = 0;
    lat3 = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done0 && lat0 == 0) lat0 = k;
      if (done3 && lat3 == 0) lat3 = k;
      if (lat3 != 0) break;
    end
    check("t6_s3_latency", 32'(lat3), 32'd64);
    check("t6_s3_mt", 32'(mt3), 32'h5507);
    check("t6_s3_cnt", 32'(cnt3), 32'd7);
    check("t6_s3_match", 32'(match3), 32'h1);
    check("t6_s0_latency", 32'(lat0), 32'd16);
    check("t6_s0_mt", 32'(mt0), 32'hAA0F);
    check("t6_s0_cnt", 32'(cnt0), 32'd8);
    check("t6_s0_match", 32'(match0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
